pwm_compare_stage: RTL and testbench

//  Downstream consumer of the free-running up/down counter value. Turns the count into a
//  PWM waveform by comparing it against a duty-cycle register.
//  The duty register is double-buffered: a new duty is accepted through a valid/ready

---
 rtl/pwm_compare_stage.sv | 72 +++++++
 tb/tb_pwm_compare_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_compare_stage.sv
// PWM compare stage: compares the incoming counter against a double-buffered duty
// register and pulses period_done once per counter period.
module pwm_compare_stage #(
   parameter int unsigned WIDTH    = 4,
   parameter bit          UP_MODE  = 1'b1,
   parameter int unsigned DUTY_RST = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] counter,
   input  logic [WIDTH:0]   duty_in,
   input  logic             duty_valid,
   output logic             duty_ready,
   output logic             pwm_out,
   output logic             period_done
);

   localparam logic [WIDTH:0] DUTY_MAX  = {1'b1, {WIDTH{1'b0}}};
   localparam logic [WIDTH:0] DUTY_INIT = (WIDTH+1)'(DUTY_RST);

   typedef enum logic {EMPTY, FULL} shadow_state_t;

   shadow_state_t    state;
   shadow_state_t    state_next;
   logic [WIDTH-1:0] eff;
   logic             armed;
   logic             boundary;
   logic [WIDTH:0]   shadow;
   logic [WIDTH:0]   active_duty;
   logic [WIDTH:0]   duty_clamped;
   logic [WIDTH:0]   duty_use;

   // A down-counting source is folded onto the up-count view so its all-ones wrap reads as 0.
   assign eff          = UP_MODE ? counter : ~counter;
   assign boundary     = armed && (eff == '0);
   assign duty_clamped = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
   assign duty_use     = (boundary && (state == FULL)) ? shadow : active_duty;
   assign duty_ready   = (state == EMPTY);

   always_comb begin
      state_next = state;
      if (state == EMPTY) begin
         if (duty_valid) state_next = FULL;
      end else begin
         if (boundary) state_next = EMPTY;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= EMPTY;
      else       state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed       <= 1'b1;
         shadow      <= '0;
         active_duty <= DUTY_INIT;
         pwm_out     <= 1'b0;
         period_done <= 1'b0;
      end else begin
         // Disarm after a boundary so a count parked at 0 yields a single period.
         if (eff != '0)    armed <= 1'b1;
         else if (boundary) armed <= 1'b0;
         if ((state == EMPTY) && duty_valid) shadow <= duty_clamped;
         if ((state == FULL) && boundary)    active_duty <= shadow;
         pwm_out     <= ({1'b0, eff} < duty_use);
         period_done <= boundary;
      end
   end

endmodule

// File: tb/tb_pwm_compare_stage.sv
// Directed bench for pwm_compare_stage: an up-mode and a down-mode instance are
// fed by bench-driven counters and checked against hand-derived expectations.
module tb_pwm_compare_stage;

   logic       clk;
   logic       reset;
   logic [3:0] cnt_up;
   logic [3:0] cnt_dn;
   logic [4:0] duty_in;
   logic       duty_valid;
   logic [4:0] dn_duty_in;
   logic       dn_valid;
   logic       ready_up, pwm_up, pd_up;
   logic       ready_dn, pwm_dn, pd_dn;
   logic [3:0] prev_up;
   logic [3:0] prev_dn;
   logic       hold;
   int         n_cmp;
   int         n_fail;

   pwm_compare_stage #(.WIDTH(4), .UP_MODE(1'b1), .DUTY_RST(0)) dut_up (
      .clk(clk), .reset(reset), .counter(cnt_up), .duty_in(duty_in),
      .duty_valid(duty_valid), .duty_ready(ready_up), .pwm_out(pwm_up),
      .period_done(pd_up)
   );

   pwm_compare_stage #(.WIDTH(4), .UP_MODE(1'b0), .DUTY_RST(0)) dut_dn (
      .clk(clk), .reset(reset), .counter(cnt_dn), .duty_in(dn_duty_in),
      .duty_valid(dn_valid), .duty_ready(ready_dn), .pwm_out(pwm_dn),
      .period_done(pd_dn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: remember the sampled counts, then advance the source counters.
   task automatic tick();
      @(posedge clk);
      prev_up = cnt_up;
      prev_dn = cnt_dn;
      #1;
      if (!hold) cnt_up = cnt_up + 4'd1;
      cnt_dn = cnt_dn - 4'd1;
   endtask

   task automatic test_reset();
      reset = 1'b0; hold = 1'b1; cnt_up = '0; cnt_dn = '0;
      duty_in = '0; duty_valid = 1'b0; dn_duty_in = '0; dn_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (pwm_up !== 1'b0) begin n_fail++; $display("FAIL rst_pwm: got %b want 0", pwm_up); end
      n_cmp++; if (pd_up !== 1'b0) begin n_fail++; $display("FAIL rst_pd: got %b want 0", pd_up); end
      n_cmp++; if (ready_up !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", ready_up); end
      n_cmp++; if (pwm_dn !== 1'b0) begin n_fail++; $display("FAIL rst_pwm_dn: got %b want 0", pwm_dn); end
      n_cmp++; if (ready_dn !== 1'b1) begin n_fail++; $display("FAIL rst_ready_dn: got %b want 1", ready_dn); end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (pwm_up !== 1'b0) begin n_fail++; $display("FAIL rst_hold_pwm: got %b want 0", pwm_up); end
      n_cmp++; if (pd_up !== 1'b0) begin n_fail++; $display("FAIL rst_hold_pd: got %b want 0", pd_up); end
      n_cmp++; if (ready_up !== 1'b1) begin n_fail++; $display("FAIL rst_hold_ready: got %b want 1", ready_up); end
      reset = 1'b0;
      hold  = 1'b0;
   endtask

   task automatic test_first_period();
      for (int i = 0; i < 16; i++) begin
         tick();
         n_cmp++; if (pwm_up !== 1'b0) begin n_fail++; $display("FAIL first_pwm s%0d: got %b want 0", prev_up, pwm_up); end
         n_cmp++; if (pd_up !== (prev_up == 4'd0)) begin n_fail++; $display("FAIL first_pd s%0d: got %b want %b", prev_up, pd_up, prev_up == 4'd0); end
      end
   endtask

   task automatic test_handshake();
      for (int i = 0; i < 6; i++) begin
         tick();
         n_cmp++; if (pwm_up !== 1'b0) begin n_fail++; $display("FAIL hs_pre_pwm s%0d: got %b want 0", prev_up, pwm_up); end
      end
      duty_in = 5'd4; duty_valid = 1'b1;
      tick();
      duty_valid = 1'b0;
      n_cmp++; if (ready_up !== 1'b0) begin n_fail++; $display("FAIL hs_ready_low: got %b want 0", ready_up); end
      for (int i = 0; i < 9; i++) begin
         tick();
         n_cmp++; if (pwm_up !== 1'b0) begin n_fail++; $display("FAIL hs_wait_pwm s%0d: got %b want 0", prev_up, pwm_up); end
         n_cmp++; if (ready_up !== 1'b0) begin n_fail++; $display("FAIL hs_wait_ready s%0d: got %b want 0", prev_up, ready_up); end
      end
      for (int i = 0; i < 32; i++) begin
         tick();
         n_cmp++; if (pwm_up !== (prev_up < 4'd4)) begin n_fail++; $display("FAIL hs_pwm s%0d: got %b want %b", prev_up, pwm_up, prev_up < 4'd4); end
         n_cmp++; if (pd_up !== (prev_up == 4'd0)) begin n_fail++; $display("FAIL hs_pd s%0d: got %b want %b", prev_up, pd_up, prev_up == 4'd0); end
         if (i == 0) begin
            n_cmp++; if (ready_up !== 1'b1) begin n_fail++; $display("FAIL hs_ready_back: got %b want 1", ready_up); end
         end
      end
   endtask

   task automatic test_duty_extremes();
      int         exp_d [4];
      logic [4:0] sub   [3];
      exp_d = '{4, 16, 16, 0};
      sub   = '{5'd16, 5'd20, 5'd0};
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 16; i++) begin
            tick();
            n_cmp++; if (pwm_up !== (int'(prev_up) < exp_d[p])) begin n_fail++; $display("FAIL ext_pwm p%0d s%0d: got %b want %b", p, prev_up, pwm_up, int'(prev_up) < exp_d[p]); end
            n_cmp++; if (pd_up !== (prev_up == 4'd0)) begin n_fail++; $display("FAIL ext_pd p%0d s%0d: got %b want %b", p, prev_up, pd_up, prev_up == 4'd0); end
            if (p > 0 && i == 0) begin
               n_cmp++; if (ready_up !== 1'b1) begin n_fail++; $display("FAIL ext_ready_back p%0d: got %b want 1", p, ready_up); end
            end
            if (p < 3 && i == 2) begin duty_in = sub[p]; duty_valid = 1'b1; end
            if (p < 3 && i == 3) begin
               n_cmp++; if (ready_up !== 1'b0) begin n_fail++; $display("FAIL ext_ready_low p%0d: got %b want 0", p, ready_up); end
               duty_valid = 1'b0;
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         tick();
         n_cmp++; if (pwm_up !== 1'b0) begin n_fail++; $display("FAIL b2b_a_pwm s%0d: got %b want 0", prev_up, pwm_up); end
         if (i == 3) begin duty_in = 5'd4; duty_valid = 1'b1; end
         if (i == 4) begin
            n_cmp++; if (ready_up !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got %b want 0", ready_up); end
            duty_in = 5'd9;
         end
      end
      for (int i = 0; i < 16; i++) begin
         tick();
         n_cmp++; if (pwm_up !== (prev_up < 4'd4)) begin n_fail++; $display("FAIL b2b_b_pwm s%0d: got %b want %b", prev_up, pwm_up, prev_up < 4'd4); end
         if (i == 0) begin
            n_cmp++; if (ready_up !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_xfer: got %b want 1", ready_up); end
         end
         if (i == 1) begin
            n_cmp++; if (ready_up !== 1'b0) begin n_fail++; $display("FAIL b2b_accept9: got %b want 0", ready_up); end
            duty_valid = 1'b0;
         end
      end
      for (int i = 0; i < 16; i++) begin
         tick();
         n_cmp++; if (pwm_up !== (prev_up < 4'd9)) begin n_fail++; $display("FAIL b2b_c_pwm s%0d: got %b want %b", prev_up, pwm_up, prev_up < 4'd9); end
         n_cmp++; if (pd_up !== (prev_up == 4'd0)) begin n_fail++; $display("FAIL b2b_c_pd s%0d: got %b want %b", prev_up, pd_up, prev_up == 4'd0); end
         if (i == 0) begin
            n_cmp++; if (ready_up !== 1'b1) begin n_fail++; $display("FAIL b2b_c_ready: got %b want 1", ready_up); end
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 8; i++) begin
         tick();
         n_cmp++; if (pwm_up !== (prev_up < 4'd9)) begin n_fail++; $display("FAIL mid_pwm s%0d: got %b want %b", prev_up, pwm_up, prev_up < 4'd9); end
         if (i == 2) begin duty_in = 5'd12; duty_valid = 1'b1; end
         if (i == 3) begin
            n_cmp++; if (ready_up !== 1'b0) begin n_fail++; $display("FAIL mid_pending: got %b want 0", ready_up); end
            duty_valid = 1'b0;
         end
      end
      reset = 1'b1; hold = 1'b1; cnt_up = '0;
      #1;
      n_cmp++; if (ready_up !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 1", ready_up); end
      n_cmp++; if (pwm_up !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pwm: got %b want 0", pwm_up); end
      n_cmp++; if (pd_up !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pd: got %b want 0", pd_up); end
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (pd_up !== (i == 0)) begin n_fail++; $display("FAIL held0_pd i%0d: got %b want %b", i, pd_up, i == 0); end
         n_cmp++; if (pwm_up !== 1'b0) begin n_fail++; $display("FAIL held0_pwm i%0d: got %b want 0", i, pwm_up); end
         n_cmp++; if (ready_up !== 1'b1) begin n_fail++; $display("FAIL held0_ready i%0d: got %b want 1", i, ready_up); end
         if (i == 1) hold = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
         tick();
         n_cmp++; if (pwm_up !== 1'b0) begin n_fail++; $display("FAIL post_rst_pwm s%0d: got %b want 0", prev_up, pwm_up); end
         n_cmp++; if (pd_up !== (prev_up == 4'd0)) begin n_fail++; $display("FAIL post_rst_pd s%0d: got %b want %b", prev_up, pd_up, prev_up == 4'd0); end
      end
   endtask

   task automatic test_down_mode();
      cnt_dn = 4'd5; dn_duty_in = 5'd4; dn_valid = 1'b1;
      tick();
      dn_valid = 1'b0;
      n_cmp++; if (ready_dn !== 1'b0) begin n_fail++; $display("FAIL dn_ready_low: got %b want 0", ready_dn); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++; if (pwm_dn !== 1'b0) begin n_fail++; $display("FAIL dn_pre_pwm c%0d: got %b want 0", prev_dn, pwm_dn); end
         n_cmp++; if (pd_dn !== 1'b0) begin n_fail++; $display("FAIL dn_pre_pd c%0d: got %b want 0", prev_dn, pd_dn); end
      end
      for (int i = 0; i < 17; i++) begin
         tick();
         n_cmp++; if (pwm_dn !== (prev_dn >= 4'd12)) begin n_fail++; $display("FAIL dn_pwm c%0d: got %b want %b", prev_dn, pwm_dn, prev_dn >= 4'd12); end
         n_cmp++; if (pd_dn !== (prev_dn == 4'd15)) begin n_fail++; $display("FAIL dn_pd c%0d: got %b want %b", prev_dn, pd_dn, prev_dn == 4'd15); end
         if (i == 0) begin
            n_cmp++; if (ready_dn !== 1'b1) begin n_fail++; $display("FAIL dn_ready_back: got %b want 1", ready_dn); end
         end
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_first_period();
      test_handshake();
      test_duty_extremes();
      test_back_to_back();
      test_reset_mid();
      test_down_mode();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
